// File: rtl/hsci_phy_rst_seq.sv
// hsci_phy_rst_seq: orders PHY PLL reset, bitslice reset and EN_VTC, and returns synced PHY status to the HSCI master.
// Optional: define HSCI_RST_SEQ_LOL_RESTART_EN to restart the sequence on loss of lock while in DONE.
module hsci_phy_rst_seq #(
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int BSC_RST_CYCLES = 16,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       s_axi_aclk,
    input  logic       s_axi_areset,
    input  logic       seq_restart,
    input  logic       phy_pll_locked,
    input  logic       phy_dly_rdy_tx,
    input  logic       phy_dly_rdy_rx,
    input  logic       phy_vtc_rdy_tx,
    input  logic       phy_vtc_rdy_rx,
    output logic       phy_pll_rst,
    output logic       phy_bsc_rst,
    output logic       phy_en_vtc,
    output logic       hsci_pll_locked,
    output logic       hsci_dly_rdy_bsc_tx,
    output logic       hsci_dly_rdy_bsc_rx,
    output logic       hsci_vtc_rdy_bsc_tx,
    output logic       hsci_vtc_rdy_bsc_rx,
    output logic       hsci_rst_seq_done,
    output logic [2:0] seq_state,
    output logic       seq_error,
    output logic [2:0] seq_retry_cnt
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        BSC_RST   = 3'd2,
        WAIT_DLY  = 3'd3,
        WAIT_VTC  = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    // One counter serves every timed state, so it must hold the largest terminal count.
    localparam int MAX_PB  = (PLL_RST_CYCLES > BSC_RST_CYCLES) ? PLL_RST_CYCLES : BSC_RST_CYCLES;
    localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_PB) ? LOCK_TIMEOUT : MAX_PB;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BSC_LAST  = CNT_W'(BSC_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    state_t                        state, state_n;
    logic [CNT_W-1:0]              cnt, cnt_n;
    logic [2:0]                    retry_q, retry_n;
    logic                          error_q, error_n;
    logic                          restart_q;
    logic                          restart_rise;
    logic                          take_retry;
    logic                          pll_rst_q, bsc_rst_q, en_vtc_q, done_q;
    logic                          pll_rst_n, bsc_rst_n, en_vtc_n, done_n;
    logic [4:0]                    raw_flags;
    logic [SYNC_STAGES-1:0][4:0]   sync_q;
    logic [4:0]                    sync_flags;
    logic                          lock_s, dly_ok, vtc_ok, tmo;

    assign raw_flags = {phy_pll_locked, phy_dly_rdy_tx, phy_dly_rdy_rx, phy_vtc_rdy_tx, phy_vtc_rdy_rx};

    // Plain flop chain per status bit; stage 0 is the metastability catcher.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_flags};
        end
    end

    assign sync_flags = sync_q[SYNC_STAGES-1];
    assign lock_s     = sync_flags[4];
    assign dly_ok     = sync_flags[3] & sync_flags[2];
    assign vtc_ok     = sync_flags[1] & sync_flags[0];
    assign tmo        = (cnt == TMO_LAST);

    assign restart_rise = seq_restart & ~restart_q;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            retry_q   <= '0;
            error_q   <= 1'b0;
            restart_q <= 1'b0;
            pll_rst_q <= 1'b1;
            bsc_rst_q <= 1'b1;
            en_vtc_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_q   <= retry_n;
            error_q   <= error_n;
            restart_q <= seq_restart;
            pll_rst_q <= pll_rst_n;
            bsc_rst_q <= bsc_rst_n;
            en_vtc_q  <= en_vtc_n;
            done_q    <= done_n;
        end
    end

    // PHY controls are registered from the next state so they never glitch and line up with seq_state.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        retry_n    = retry_q;
        error_n    = error_q;
        take_retry = 1'b0;

        case (state)
            PLL_RST: begin
                if (restart_q) begin
                    cnt_n = '0;
                end else if (cnt == PLL_LAST) begin
                    state_n = WAIT_LOCK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = BSC_RST;
                end else if (tmo) begin
                    take_retry = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BSC_RST: begin
                if (cnt == BSC_LAST) begin
                    state_n = WAIT_DLY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DLY: begin
                if (dly_ok) begin
                    state_n = WAIT_VTC;
                end else if (tmo) begin
                    take_retry = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_VTC: begin
                if (vtc_ok) begin
                    state_n = DONE;
                end else if (tmo) begin
                    take_retry = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
`ifdef HSCI_RST_SEQ_LOL_RESTART_EN
                if (!lock_s) begin
                    take_retry = 1'b1;
                end
`else
                state_n = DONE;
`endif
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = PLL_RST;
            end
        endcase

        if (take_retry) begin
            if (retry_q < RETRY_MAX) begin
                retry_n = retry_q + 1'b1;
                state_n = PLL_RST;
            end else begin
                error_n = 1'b1;
                state_n = ERROR;
            end
        end

        // A master restart overrides everything, including a timeout in the same cycle.
        if (restart_rise) begin
            state_n = PLL_RST;
            retry_n = '0;
            error_n = 1'b0;
        end

        if ((state_n != state) || restart_rise) begin
            cnt_n = '0;
        end

        pll_rst_n = (state_n == PLL_RST) || (state_n == ERROR);
        bsc_rst_n = (state_n == PLL_RST) || (state_n == WAIT_LOCK) ||
                    (state_n == BSC_RST) || (state_n == ERROR);
        en_vtc_n  = (state_n == WAIT_VTC) || (state_n == DONE);
        done_n    = (state_n == DONE);
    end

    assign phy_pll_rst         = pll_rst_q;
    assign phy_bsc_rst         = bsc_rst_q;
    assign phy_en_vtc          = en_vtc_q;
    assign hsci_rst_seq_done   = done_q;
    assign seq_state           = state;
    assign seq_error           = error_q;
    assign seq_retry_cnt       = retry_q;
    assign hsci_pll_locked     = sync_flags[4];
    assign hsci_dly_rdy_bsc_tx = sync_flags[3];
    assign hsci_dly_rdy_bsc_rx = sync_flags[2];
    assign hsci_vtc_rdy_bsc_tx = sync_flags[1];
    assign hsci_vtc_rdy_bsc_rx = sync_flags[0];

endmodule

// File: tb/tb_hsci_phy_rst_seq.sv
// Directed bench for hsci_phy_rst_seq: bring-up, loss of lock, restarts, lock timeout/ERROR and mid-sequence reset.
`timescale 1ns/1ps
module tb_hsci_phy_rst_seq;

    localparam logic [2:0] S_PLL  = 3'd0;
    localparam logic [2:0] S_LOCK = 3'd1;
    localparam logic [2:0] S_BSC  = 3'd2;
    localparam logic [2:0] S_DLY  = 3'd3;
    localparam logic [2:0] S_VTC  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic       s_axi_aclk = 1'b0;
    logic       s_axi_areset;
    logic       seq_restart;
    logic       phy_pll_locked, phy_dly_rdy_tx, phy_dly_rdy_rx, phy_vtc_rdy_tx, phy_vtc_rdy_rx;
    logic       phy_pll_rst, phy_bsc_rst, phy_en_vtc;
    logic       hsci_pll_locked, hsci_dly_rdy_bsc_tx, hsci_dly_rdy_bsc_rx;
    logic       hsci_vtc_rdy_bsc_tx, hsci_vtc_rdy_bsc_rx, hsci_rst_seq_done;
    logic [2:0] seq_state;
    logic       seq_error;
    logic [2:0] seq_retry_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int pll_high  = 0;
    int guard     = 0;

    always #5 s_axi_aclk = ~s_axi_aclk;

    hsci_phy_rst_seq #(
        .PLL_RST_CYCLES (64),
        .LOCK_TIMEOUT   (64),
        .BSC_RST_CYCLES (16),
        .MAX_RETRY      (3),
        .SYNC_STAGES    (2)
    ) dut (
        .s_axi_aclk          (s_axi_aclk),
        .s_axi_areset        (s_axi_areset),
        .seq_restart         (seq_restart),
        .phy_pll_locked      (phy_pll_locked),
        .phy_dly_rdy_tx      (phy_dly_rdy_tx),
        .phy_dly_rdy_rx      (phy_dly_rdy_rx),
        .phy_vtc_rdy_tx      (phy_vtc_rdy_tx),
        .phy_vtc_rdy_rx      (phy_vtc_rdy_rx),
        .phy_pll_rst         (phy_pll_rst),
        .phy_bsc_rst         (phy_bsc_rst),
        .phy_en_vtc          (phy_en_vtc),
        .hsci_pll_locked     (hsci_pll_locked),
        .hsci_dly_rdy_bsc_tx (hsci_dly_rdy_bsc_tx),
        .hsci_dly_rdy_bsc_rx (hsci_dly_rdy_bsc_rx),
        .hsci_vtc_rdy_bsc_tx (hsci_vtc_rdy_bsc_tx),
        .hsci_vtc_rdy_bsc_rx (hsci_vtc_rdy_bsc_rx),
        .hsci_rst_seq_done   (hsci_rst_seq_done),
        .seq_state           (seq_state),
        .seq_error           (seq_error),
        .seq_retry_cnt       (seq_retry_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // outs = {phy_pll_rst, phy_bsc_rst, phy_en_vtc, hsci_rst_seq_done}
    task automatic checkCore(input string tag, input logic [2:0] st, input logic [3:0] outs,
                             input logic err, input logic [2:0] retry);
        checkOutput(tag,
                    32'({seq_state, phy_pll_rst, phy_bsc_rst, phy_en_vtc, hsci_rst_seq_done, seq_error, seq_retry_cnt}),
                    32'({st, outs, err, retry}));
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge s_axi_aclk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [4:0] syncFlags();
        return {hsci_pll_locked, hsci_dly_rdy_bsc_tx, hsci_dly_rdy_bsc_rx, hsci_vtc_rdy_bsc_tx, hsci_vtc_rdy_bsc_rx};
    endfunction

    initial begin
        s_axi_areset   = 1'b1;
        seq_restart    = 1'b0;
        phy_pll_locked = 1'b0;
        phy_dly_rdy_tx = 1'b0;
        phy_dly_rdy_rx = 1'b0;
        phy_vtc_rdy_tx = 1'b0;
        phy_vtc_rdy_rx = 1'b0;
        repeat (4) @(posedge s_axi_aclk);
        #1;
        s_axi_areset = 1'b0;
        cyc = 0;

        $display("[TB] normal bring-up");
        checkCore("rst", S_PLL, 4'b1100, 1'b0, 3'd0);
        checkOutput("rst_sync", 32'(syncFlags()), 32'd0);
        while (cyc < 205) begin
            if (phy_pll_rst) pll_high++;
            if (cyc == 100) phy_pll_locked = 1'b1;
            if (cyc == 140) phy_dly_rdy_tx = 1'b1;
            if (cyc == 150) phy_dly_rdy_rx = 1'b1;
            if (cyc == 190) phy_vtc_rdy_rx = 1'b1;
            if (cyc == 200) phy_vtc_rdy_tx = 1'b1;
            applyStimulus(1);
            case (cyc)
                63:  checkCore("n63", S_PLL, 4'b1100, 1'b0, 3'd0);
                64:  checkCore("n64", S_LOCK, 4'b0100, 1'b0, 3'd0);
                101: checkOutput("n_lk101", 32'(hsci_pll_locked), 32'd0);
                102: checkOutput("n_lk102", 32'(hsci_pll_locked), 32'd1);
                103: checkCore("n103", S_BSC, 4'b0100, 1'b0, 3'd0);
                118: checkCore("n118", S_BSC, 4'b0100, 1'b0, 3'd0);
                119: checkCore("n119", S_DLY, 4'b0000, 1'b0, 3'd0);
                152: checkCore("n152", S_DLY, 4'b0000, 1'b0, 3'd0);
                153: checkCore("n153", S_VTC, 4'b0010, 1'b0, 3'd0);
                202: checkCore("n202", S_VTC, 4'b0010, 1'b0, 3'd0);
                203: checkCore("n203", S_DONE, 4'b0011, 1'b0, 3'd0);
                default: ;
            endcase
        end
        checkOutput("n_pll_high", 32'(pll_high), 32'd64);

        $display("[TB] loss of lock in DONE");
        applyStimulus(5);
        phy_pll_locked = 1'b0;
        applyStimulus(1);
        checkOutput("lol_lk1", 32'(hsci_pll_locked), 32'd1);
        applyStimulus(1);
        checkOutput("lol_lk2", 32'(hsci_pll_locked), 32'd0);
        applyStimulus(1);
`ifdef HSCI_RST_SEQ_LOL_RESTART_EN
        checkCore("lol3", S_PLL, 4'b1100, 1'b0, 3'd1);
`else
        checkCore("lol3", S_DONE, 4'b0011, 1'b0, 3'd0);
`endif
        phy_pll_locked = 1'b1;
        applyStimulus(1);
        checkOutput("lol_lk4", 32'(hsci_pll_locked), 32'd0);
        applyStimulus(1);
        checkOutput("lol_lk5", 32'(hsci_pll_locked), 32'd1);
        guard = 0;
        while (!hsci_rst_seq_done && guard < 300) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("lol_done", 32'(hsci_rst_seq_done), 32'd1);

        $display("[TB] restart held in DONE");
        applyStimulus(3);
        checkOutput("rh_pre_done", 32'(hsci_rst_seq_done), 32'd1);
        seq_restart = 1'b1;
        pll_high = 0;
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1);
            if (phy_pll_rst) pll_high++;
            if (k == 10) seq_restart = 1'b0;
            case (k)
                1:  checkCore("rh1", S_PLL, 4'b1100, 1'b0, 3'd0);
                74: checkCore("rh74", S_PLL, 4'b1100, 1'b0, 3'd0);
                75: checkCore("rh75", S_LOCK, 4'b0100, 1'b0, 3'd0);
                93: checkCore("rh93", S_VTC, 4'b0010, 1'b0, 3'd0);
                94: checkCore("rh94", S_DONE, 4'b0011, 1'b0, 3'd0);
                default: ;
            endcase
        end
        checkOutput("rh_pll_high", 32'(pll_high), 32'd74);

        $display("[TB] lock timeout and retries");
        phy_pll_locked = 1'b0;
        seq_restart    = 1'b1;
        for (int k = 1; k <= 530; k++) begin
            applyStimulus(1);
            if (k == 1) seq_restart = 1'b0;
            case (k)
                1:   checkCore("to1", S_PLL, 4'b1100, 1'b0, 3'd0);
                65:  checkCore("to65", S_PLL, 4'b1100, 1'b0, 3'd0);
                66:  checkCore("to66", S_LOCK, 4'b0100, 1'b0, 3'd0);
                129: checkCore("to129", S_LOCK, 4'b0100, 1'b0, 3'd0);
                130: checkCore("to130", S_PLL, 4'b1100, 1'b0, 3'd1);
                194: checkCore("to194", S_LOCK, 4'b0100, 1'b0, 3'd1);
                258: checkCore("to258", S_PLL, 4'b1100, 1'b0, 3'd2);
                386: checkCore("to386", S_PLL, 4'b1100, 1'b0, 3'd3);
                513: checkCore("to513", S_LOCK, 4'b0100, 1'b0, 3'd3);
                514: checkCore("to514", S_ERR, 4'b1100, 1'b1, 3'd3);
                530: checkCore("to530", S_ERR, 4'b1100, 1'b1, 3'd3);
                default: ;
            endcase
        end

        $display("[TB] restart from ERROR");
        phy_pll_locked = 1'b1;
        seq_restart    = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            applyStimulus(1);
            if (k == 1) seq_restart = 1'b0;
            case (k)
                1:  checkCore("re1", S_PLL, 4'b1100, 1'b0, 3'd0);
                66: checkCore("re66", S_LOCK, 4'b0100, 1'b0, 3'd0);
                84: checkCore("re84", S_VTC, 4'b0010, 1'b0, 3'd0);
                85: checkCore("re85", S_DONE, 4'b0011, 1'b0, 3'd0);
                default: ;
            endcase
        end

        $display("[TB] reset during WAIT_VTC");
        phy_vtc_rdy_tx = 1'b0;
        phy_vtc_rdy_rx = 1'b0;
        seq_restart    = 1'b1;
        for (int k = 1; k <= 93; k++) begin
            applyStimulus(1);
            if (k == 1) seq_restart = 1'b0;
            case (k)
                84: checkCore("mr84", S_VTC, 4'b0010, 1'b0, 3'd0);
                90: begin
                    checkCore("mr90", S_VTC, 4'b0010, 1'b0, 3'd0);
                    s_axi_areset = 1'b1;
                end
                91: begin
                    checkCore("mr91", S_PLL, 4'b1100, 1'b0, 3'd0);
                    checkOutput("mr91_sync", 32'(syncFlags()), 32'd0);
                    s_axi_areset = 1'b0;
                end
                92: checkOutput("mr92_sync", 32'(syncFlags()), 32'd0);
                93: checkOutput("mr93_sync", 32'(syncFlags()), 32'h1c);
                default: ;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
